// File: rtl/sync_event_pacer.sv
// -----------------------------------------------------------------------------
// sync_event_pacer
// Source-domain (clk_in) pacing stage placed in front of a pulse synchronizer.
// Bursty single-cycle events and their payloads are queued in a small FIFO.
// They are then issued one at a time as 1-cycle sync_req pulses. A guard
// interval separates consecutive pulses, so a new event never lands on a
// handshake that is still in flight. The payload of the last issued event is
// held on hold_data for the destination domain to sample.
//
// Ports:
//   clk_in     in   source-domain clock
//   reset_n    in   asynchronous active-low reset, clears all state
//   ev_valid   in   event strobe, one event per high cycle
//   ev_data    in   event payload, sampled with ev_valid
//   ev_ready   out  FIFO not full (combinational from the full flag)
//   ovf_clr    in   clears the sticky overflow flag (a same-cycle set wins)
//   sync_req   out  1-cycle issue pulse towards the synchronizer sync_in
//   hold_data  out  payload of the most recently issued event
//   busy       out  high in the ISSUE and GUARD states
//   pending    out  FIFO occupancy, 0..DEPTH
//   overflow   out  sticky, set when an event is dropped
// -----------------------------------------------------------------------------
module sync_event_pacer #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int GUARD_CYCLES = 16,
  parameter int CNT_W        = 3
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              ev_valid,
  input  logic [DATA_W-1:0] ev_data,
  output logic              ev_ready,
  input  logic              ovf_clr,
  output logic              sync_req,
  output logic [DATA_W-1:0] hold_data,
  output logic              busy,
  output logic [CNT_W-1:0]  pending,
  output logic              overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       guard_q, guard_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   hold_q;
  logic                ovf_q;

  logic full_s, empty_s, pop_s, push_s, drop_s;

  assign full_s  = (cnt_q == CNT_W'(DEPTH));
  assign empty_s = (cnt_q == {CNT_W{1'b0}});
  // Pop is decided from registered state only, so a push in the same cycle
  // is safe even when full: the head slot is freed at the same edge.
  assign pop_s   = (state_q == S_IDLE) && !empty_s;
  assign push_s  = ev_valid && (!full_s || pop_s);
  assign drop_s  = ev_valid && !push_s;

  assign ev_ready  = !full_s;
  assign pending   = cnt_q;
  assign hold_data = hold_q;
  assign overflow  = ovf_q;

  // FSM state and guard counter register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      guard_q <= {GW{1'b0}};
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
    end
  end

  // FSM next-state and guard counter logic
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        guard_d = GW'(GUARD_CYCLES - 1);
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_q == {GW{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        guard_d = {GW{1'b0}};
      end
    endcase
  end

  // FSM outputs decoded from registered state; reset drops them at once
  always_comb begin
    sync_req = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_ISSUE: begin
        sync_req = 1'b1;
        busy     = 1'b1;
      end
      S_GUARD: begin
        busy = 1'b1;
      end
      default: begin
        sync_req = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // FIFO storage, pointers, occupancy and issued-payload holding register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      hold_q   <= {DATA_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= ev_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        hold_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as ovf_clr keeps it set
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop_s) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q;
    end
  end

endmodule
